// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite types for the memory-backed slave:
//   htrans_e        - HTRANS encodings
//   hresp_e         - HRESP encodings
//   ahb_slv_state_e - slave response FSM states (ST_WAIT exists only when
//                     KVIPS_AHB_SLV_WAIT_EN is defined)
//   ahb_byte_mask   - byte-lane strobe for a given HSIZE and address LSBs
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_pkg;

  // Widest supported data bus is 64 bits, i.e. 8 byte lanes.
  localparam int AHB_MAX_STRB = 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_e;

`ifdef KVIPS_AHB_SLV_WAIT_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_slv_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_slv_state_e;
`endif

  // Strobe for a transfer of 2**size bytes starting at byte lane addr_lsb.
  // Callers narrower than 64 bits keep only the low DATA_W/8 bits.
  function automatic logic [AHB_MAX_STRB-1:0] ahb_byte_mask(
    input logic [2:0] size,
    input logic [2:0] addr_lsb
  );
    logic [AHB_MAX_STRB-1:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << addr_lsb;
  endfunction

endpackage

// File: rtl/ahb_mem_slave_ram.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave_ram
// Word-organised byte-enable RAM of MEM_BYTES bytes with an asynchronous
// read port sharing the write address. Contents are not reset.
// Ports:
//   i_clk    - write clock
//   i_we     - write enable
//   i_addr   - word address (read and write)
//   i_be     - byte-lane write enables
//   i_wdata  - write data
//   o_rdata  - combinational read data at i_addr
// ---------------------------------------------------------------------------
module ahb_mem_slave_ram #(
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096,
  parameter int AW        = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = MEM_BYTES / NB;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave
// AHB-Lite memory-backed slave. Accepts address phases, decodes range/size/
// alignment errors, and answers with OKAY (optionally wait-stated) or the
// two-cycle ERROR response. Reads are combinational from the RAM during the
// completion cycle; writes commit on the completion edge.
// Optional feature macro: KVIPS_AHB_SLV_WAIT_EN - builds ST_WAIT and the
// 4-bit wait counter so WAIT_CYCLES (0..15) is honoured; otherwise every
// OKAY transfer is zero-wait.
// Ports:
//   HCLK, HRESETn          - clock, async active-low reset
//   HSEL, HADDR, HTRANS    - select, address, transfer type
//   HWRITE, HSIZE          - direction, log2 bytes
//   HBURST, HPROT          - ignored
//   HWDATA                 - write data (data phase)
//   HREADY                 - global ready
//   HREADYOUT, HRESP       - slave ready, response
//   HRDATA                 - read data (zero outside read completion)
// ---------------------------------------------------------------------------
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int MA  = $clog2(MEM_BYTES);
  localparam int WA  = MA - LSB;

  ahb_slv_state_e r_state, w_state_nxt;

  logic [MA-1:0]     r_addr;
  logic              r_write;
  logic [2:0]        r_size;

  logic              w_accept;
  logic              w_can_accept;
  logic              w_err;
  logic [7:0]        w_align_mask;
  logic [2:0]        w_lane;
  logic              w_we;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_rdata;

  // HBURST/HPROT are don't-care; HTRANS[0] only separates IDLE/BUSY and
  // NONSEQ/SEQ, neither of which changes how a beat is handled.
  logic w_unused;
  assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

`ifdef KVIPS_AHB_SLV_WAIT_EN
  logic [3:0] r_cnt, w_cnt_nxt;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  // Address-phase decode
  // A new address can only land when the previous data phase is finishing
  // (or there is none); the master holds its address through wait/ERR1.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                        (r_state == ST_ERR2);
  assign w_accept     = HSEL && HREADY && HTRANS[1] && w_can_accept;

  // Alignment only matters for legal sizes; oversize is flagged separately.
  assign w_align_mask = (8'd1 << HSIZE) - 8'd1;
  assign w_err = (HADDR >= ADDR_W'(MEM_BYTES)) ||
                 (HSIZE > 3'(LSB)) ||
                 ((HADDR[7:0] & w_align_mask) != 8'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
`ifdef KVIPS_AHB_SLV_WAIT_EN
      r_cnt   <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
`ifdef KVIPS_AHB_SLV_WAIT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  // Data-phase register: captured on accept, no reset needed because the
  // FSM state alone decides whether it is meaningful.
  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_addr  <= HADDR[MA-1:0];
      r_write <= HWRITE;
      r_size  <= HSIZE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef KVIPS_AHB_SLV_WAIT_EN
    w_cnt_nxt   = r_cnt;
`endif
    HREADYOUT   = 1'b1;
    HRESP       = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (r_state == ST_ERR2) HRESP = HRESP_ERROR;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
`ifdef KVIPS_AHB_SLV_WAIT_EN
          end else if (WAIT_CYCLES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
`endif
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef KVIPS_AHB_SLV_WAIT_EN
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
`endif
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory port
  assign w_lane = 3'(r_addr) & 3'(NB - 1);
  assign w_be   = NB'(ahb_byte_mask(r_size, w_lane));
  assign w_we   = (r_state == ST_DATA) && r_write;

  ahb_mem_slave_ram #(
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES),
    .AW        (WA)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_addr  (r_addr[MA-1:LSB]),
    .i_be    (w_be),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HRDATA = ((r_state == ST_DATA) && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_slave
// Directed bench for ahb_mem_slave (32-bit data, 4 KiB). A pipelined driver
// issues beats and pushes the expected per-cycle response into a queue,
// stamped with the cycle it must appear in; a monitor on the falling edge
// pops and compares. With KVIPS_AHB_SLV_WAIT_EN the DUT uses 3 wait states
// and an asynchronous reset is applied in the middle of a wait sequence.
// ---------------------------------------------------------------------------
module tb_ahb_mem_slave;
  import ahb_pkg::*;

`ifdef KVIPS_AHB_SLV_WAIT_EN
  localparam int WC = 3;
`else
  localparam int WC = 0;
`endif

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = HTRANS_IDLE;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'd0;
  logic [2:0]  HBURST  = 3'd0;
  logic [3:0]  HPROT   = 4'd0;
  logic [31:0] HWDATA  = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  // Single slave on the bus: global ready is this slave's ready.
  assign HREADY = HREADYOUT;

  ahb_mem_slave #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_BYTES   (4096),
    .WAIT_CYCLES (WC)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] pend_wdata = '0;

  task automatic expect_at(input int c, input logic rdy, input logic [1:0] resp,
                           input logic [31:0] rd, input string nm);
    exp_t e;
    e.cyc = c; e.rdy = rdy; e.resp = resp; e.rdata = rd; e.name = nm;
    q.push_back(e);
  endtask

  // Presents one address phase (plus the previous beat's write data), waits
  // for it to be accepted, then queues the expected response cycles.
  task automatic beat(input string nm, input logic sel, input logic [1:0] trans,
                      input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit err, input logic [31:0] rd);
    int a;
    int guard;
    guard  = 0;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HWDATA = pend_wdata;
    @(negedge HCLK);
    while (!HREADYOUT && guard < 40) begin
      @(negedge HCLK);
      guard++;
    end
    if (!HREADYOUT) begin
      n_total++;
      $display("FAIL %s_accept: HREADYOUT=%b after %0d cycles, want 1", nm, HREADYOUT, guard);
    end
    @(posedge HCLK);
    #1;
    a = cyc;
    pend_wdata = wdata;
    if (!(sel && trans[1])) begin
      expect_at(a, 1'b1, HRESP_OKAY, 32'h0, {nm, "_idle"});
    end else if (err) begin
      expect_at(a,     1'b0, HRESP_ERROR, 32'h0, {nm, "_err1"});
      expect_at(a + 1, 1'b1, HRESP_ERROR, 32'h0, {nm, "_err2"});
    end else begin
      for (int k = 0; k < WC; k++) expect_at(a + k, 1'b0, HRESP_OKAY, 32'h0, {nm, "_wait"});
      expect_at(a + WC, 1'b1, HRESP_OKAY, wr ? 32'h0 : rd, nm);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge HCLK);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_total++;
        if (e.cyc != cyc) begin
          $display("FAIL %s: response for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
        end else if (HREADYOUT !== e.rdy || HRESP !== e.resp || HRDATA !== e.rdata) begin
          $display("FAIL %s: got rdy=%b resp=%0d rdata=%h, want rdy=%b resp=%0d rdata=%h",
                   e.name, HREADYOUT, HRESP, HRDATA, e.rdy, e.resp, e.rdata);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    expect_at(cyc, 1'b1, HRESP_OKAY, 32'h0, "in_reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    expect_at(cyc, 1'b1, HRESP_OKAY, 32'h0, "after_reset");

    //   name           sel   trans          wr    size  addr          wdata         err   rdata
    beat("wr_10",       1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0);
    beat("rd_10",       1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF);
    beat("wr_20",       1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h0000_0020, 32'h11223344, 1'b0, 32'h0);
    beat("wrb_21",      1'b1, HTRANS_NONSEQ, 1'b1, 3'd0, 32'h0000_0021, 32'h0000AA00, 1'b0, 32'h0);
    beat("wrh_22",      1'b1, HTRANS_SEQ,    1'b1, 3'd1, 32'h0000_0022, 32'h55660000, 1'b0, 32'h0);
    beat("rd_20",       1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0020, 32'h0,        1'b0, 32'h5566AA44);
    beat("rd_top",      1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_1000, 32'h0,        1'b1, 32'h0);
    beat("rd_10_err2",  1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF);
    beat("wr_00",       1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h0000_0000, 32'hCAFEF00D, 1'b0, 32'h0);
    beat("wr_mis",      1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h0000_0002, 32'hFFFFFFFF, 1'b1, 32'h0);
    beat("rd_00",       1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0000, 32'h0,        1'b0, 32'hCAFEF00D);
    beat("rd_size",     1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h0000_0008, 32'h0,        1'b1, 32'h0);
    beat("wr_nosel",    1'b0, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 32'h0);
    beat("busy",        1'b1, HTRANS_BUSY,   1'b1, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 32'h0);
    beat("rd_10_again", 1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF);
    beat("wr_ffc",      1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h0000_0FFC, 32'hA5A55A5A, 1'b0, 32'h0);
    beat("rd_ffc",      1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0FFC, 32'h0,        1'b0, 32'hA5A55A5A);
    beat("rd_mis_h",    1'b1, HTRANS_NONSEQ, 1'b0, 3'd1, 32'h0000_0021, 32'h0,        1'b1, 32'h0);
    beat("idle_a",      1'b1, HTRANS_IDLE,   1'b0, 3'd2, 32'h0000_0000, 32'h0,        1'b0, 32'h0);
    beat("idle_b",      1'b0, HTRANS_IDLE,   1'b0, 3'd2, 32'h0000_0000, 32'h0,        1'b0, 32'h0);

`ifdef KVIPS_AHB_SLV_WAIT_EN
    begin
      int a;
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h10;
      @(posedge HCLK);
      #1;
      a = cyc;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      expect_at(a, 1'b0, HRESP_OKAY, 32'h0, "rst_wait1");
      @(posedge HCLK);
      #1;
      HRESETn = 1'b0;
      #1;
      expect_at(cyc, 1'b1, HRESP_OKAY, 32'h0, "rst_async");
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      expect_at(cyc, 1'b1, HRESP_OKAY, 32'h0, "rst_release");
      beat("rd_10_post", 1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b0, 32'hDEADBEEF);
      beat("idle_c",     1'b0, HTRANS_IDLE,   1'b0, 3'd2, 32'h0000_0000, 32'h0, 1'b0, 32'h0);
    end
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge HCLK);
    if (q.size() > 0) begin
      n_total += q.size();
      $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
